// File: rtl/dmem_responder.sv
// Data-memory responder: byte-enable word BRAM, MMIO mailbox/cycle counter,
// and an IDLE/RUN/DONE controller that gates core reset and arbitrates a host port.
module dmem_responder #(
  parameter int unsigned ADDR_WIDTH = 11,
  parameter logic [31:0] MMIO_BASE  = 32'h0000_2000,
  parameter logic [31:0] TIMEOUT    = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dmem_addr,
  input  logic        dmem_en,
  input  logic [3:0]  dmem_we,
  input  logic [31:0] dmem_din,
  output logic [31:0] dmem_dout,
  input  logic        host_start,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [31:0] host_addr,
  input  logic [31:0] host_wdata,
  output logic [31:0] host_rdata,
  output logic        host_ack,
  output logic        core_rst_n,
  output logic        done,
  output logic        timeout,
  output logic [31:0] cycle_count
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam logic [29:0] STAT_W = MMIO_BASE[31:2];
  localparam logic [29:0] CNT_W  = STAT_W + 30'd1;
  localparam logic [31:0] MAILBOX_MAGIC = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t      state_q, state_d;
  logic        core_rst_n_q, core_rst_n_d;
  logic        done_q, done_d;
  logic        timeout_q, timeout_d;
  logic [31:0] cycle_count_q, cycle_count_d;
  logic [31:0] dmem_dout_q, dmem_dout_d;
  logic [31:0] host_rdata_q, host_rdata_d;
  logic        host_ack_q, host_ack_d;

  logic [31:0] mem [DEPTH];

  logic                  core_acc, host_issue;
  logic [29:0]           acc_word;
  logic [3:0]            acc_we;
  logic [31:0]           acc_wdata;
  logic                  in_range;
  logic [ADDR_WIDTH-1:0] acc_idx;
  logic [31:0]           rd_word;
  logic                  mailbox, tmo_hit;
  logic                  unused_host_lsb;

  assign unused_host_lsb = ^host_addr[1:0];

  // Single shared memory port: the core owns it in RUN, the host otherwise.
  always_comb begin
    core_acc   = (state_q == S_RUN) && dmem_en;
    host_issue = (state_q != S_RUN) && host_req && !host_ack_q;
    if (state_q == S_RUN) begin
      acc_word  = dmem_addr[31:2];
      acc_we    = dmem_en ? dmem_we : '0;
      acc_wdata = dmem_din;
    end else begin
      acc_word  = host_addr[31:2];
      acc_we    = (host_issue && host_we) ? 4'hF : 4'h0;
      acc_wdata = host_wdata;
    end
    in_range = (acc_word[29:ADDR_WIDTH] == '0);
    acc_idx  = acc_word[ADDR_WIDTH-1:0];
    if (in_range)                rd_word = mem[acc_idx];
    else if (acc_word == STAT_W) rd_word = {30'b0, timeout_q, done_q};
    else if (acc_word == CNT_W)  rd_word = cycle_count_q;
    else                         rd_word = '0;
  end

  always_comb begin
    mailbox = core_acc && (dmem_we == 4'hF) && (dmem_addr == MMIO_BASE) &&
              (dmem_din == MAILBOX_MAGIC);
    tmo_hit = (TIMEOUT != 32'd0) && (cycle_count_q == TIMEOUT - 32'd1);
  end

  always_comb begin
    state_d       = state_q;
    core_rst_n_d  = core_rst_n_q;
    done_d        = done_q;
    timeout_d     = timeout_q;
    cycle_count_d = cycle_count_q;
    dmem_dout_d   = core_acc ? rd_word : dmem_dout_q;
    host_rdata_d  = host_issue ? rd_word : host_rdata_q;
    host_ack_d    = host_issue;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (host_start) begin
          state_d       = S_RUN;
          core_rst_n_d  = 1'b1;
          done_d        = 1'b0;
          timeout_d     = 1'b0;
          cycle_count_d = '0;
        end
      end
      S_RUN: begin
        // The terminating cycle is still counted; mailbox beats timeout.
        cycle_count_d = cycle_count_q + 32'd1;
        if (mailbox) begin
          state_d      = S_DONE;
          core_rst_n_d = 1'b0;
          done_d       = 1'b1;
        end else if (tmo_hit) begin
          state_d      = S_DONE;
          core_rst_n_d = 1'b0;
          timeout_d    = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      core_rst_n_q  <= 1'b0;
      done_q        <= 1'b0;
      timeout_q     <= 1'b0;
      cycle_count_q <= '0;
      dmem_dout_q   <= '0;
      host_rdata_q  <= '0;
      host_ack_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      core_rst_n_q  <= core_rst_n_d;
      done_q        <= done_d;
      timeout_q     <= timeout_d;
      cycle_count_q <= cycle_count_d;
      dmem_dout_q   <= dmem_dout_d;
      host_rdata_q  <= host_rdata_d;
      host_ack_q    <= host_ack_d;
    end
  end

  always_ff @(posedge clk) begin
    if (in_range) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (acc_we[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

  assign dmem_dout   = dmem_dout_q;
  assign host_rdata  = host_rdata_q;
  assign host_ack    = host_ack_q;
  assign core_rst_n  = core_rst_n_q;
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: host vector table plus hand sequences
// for the mailbox, timeout, pending host request and asynchronous reset cases.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] dmem_addr;
  logic        dmem_en;
  logic [3:0]  dmem_we;
  logic [31:0] dmem_din;
  logic [31:0] dmem_dout;
  logic        host_start;
  logic        host_req;
  logic        host_we;
  logic [31:0] host_addr;
  logic [31:0] host_wdata;
  logic [31:0] host_rdata;
  logic        host_ack;
  logic        core_rst_n;
  logic        done;
  logic        timeout;
  logic [31:0] cycle_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dmem_responder #(
    .ADDR_WIDTH(11),
    .MMIO_BASE (32'h0000_2000),
    .TIMEOUT   (32'd8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .dmem_addr  (dmem_addr),
    .dmem_en    (dmem_en),
    .dmem_we    (dmem_we),
    .dmem_din   (dmem_din),
    .dmem_dout  (dmem_dout),
    .host_start (host_start),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_rdata (host_rdata),
    .host_ack   (host_ack),
    .core_rst_n (core_rst_n),
    .done       (done),
    .timeout    (timeout),
    .cycle_count(cycle_count)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called at a falling edge; returns at a falling edge.
  task automatic host_xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rdata, output int lat, output logic ack_after);
    host_req   = 1'b1;
    host_we    = we;
    host_addr  = addr;
    host_wdata = wdata;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!host_ack && lat < 40);
    rdata    = host_rdata;
    host_req = 1'b0;
    host_we  = 1'b0;
    @(negedge clk);
    ack_after = host_ack;
  endtask

  task automatic core_drive(input logic en, input logic [3:0] we, input logic [31:0] addr,
                            input logic [31:0] din);
    dmem_en   = en;
    dmem_we   = we;
    dmem_addr = addr;
    dmem_din  = din;
  endtask

  task automatic host_read_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] rd;
    int          lat;
    logic        aa;
    host_xfer(1'b0, addr, 32'h0, rd, lat, aa);
    chk({name, "_lat"}, lat, 1);
    chk(name, rd, exp);
  endtask

  vec_t vecs[12];

  initial begin
    logic [31:0] rd;
    int          lat;
    logic        aa;
    int          k;

    vecs[0]  = '{1'b1, 32'h0000_0010, 32'h1122_3344, 32'h0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         32'h1122_3344};
    vecs[2]  = '{1'b1, 32'h0000_0014, 32'h5566_7788, 32'h0};
    vecs[3]  = '{1'b0, 32'h0000_0013, 32'h0,         32'h1122_3344};
    vecs[4]  = '{1'b0, 32'h0000_0016, 32'h0,         32'h5566_7788};
    vecs[5]  = '{1'b0, 32'h0000_2000, 32'h0,         32'h0};
    vecs[6]  = '{1'b0, 32'h0000_2004, 32'h0,         32'h0};
    vecs[7]  = '{1'b1, 32'h0000_2010, 32'hFFFF_FFFF, 32'h0};
    vecs[8]  = '{1'b0, 32'h0000_2010, 32'h0,         32'h0};
    vecs[9]  = '{1'b0, 32'h0000_0010, 32'h0,         32'h1122_3344};
    vecs[10] = '{1'b1, 32'h0000_0020, 32'h0,         32'h0};
    vecs[11] = '{1'b0, 32'h0000_1FFC, 32'h0,         32'hxxxx_xxxx};

    rst = 1'b1;
    host_start = 1'b0; host_req = 1'b0; host_we = 1'b0;
    host_addr = '0; host_wdata = '0;
    core_drive(1'b0, 4'h0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    chk("rst_core_rst_n", {31'b0, core_rst_n}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_timeout", {31'b0, timeout}, 0);
    chk("rst_cycle_count", cycle_count, 0);
    chk("rst_dmem_dout", dmem_dout, 0);
    chk("rst_host_rdata", host_rdata, 0);
    chk("rst_host_ack", {31'b0, host_ack}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Host vector table (last entry's data is uninitialised memory; only latency checked).
    for (int i = 0; i < 12; i++) begin
      host_xfer(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, lat, aa);
      chk($sformatf("vec%0d_lat", i), lat, 1);
      chk($sformatf("vec%0d_ack_pulse", i), {31'b0, aa}, 0);
      if (!vecs[i].we && i != 11) chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
    end

    // Core port ignored in IDLE: no write, dout holds.
    core_drive(1'b1, 4'hF, 32'h0000_0010, 32'h9999_9999);
    @(negedge clk);
    core_drive(1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    chk("idle_core_dout", dmem_dout, 0);
    host_read_chk("idle_core_nowrite", 32'h0000_0010, 32'h1122_3344);

    // Run with lane write, readback, MMIO reads and mailbox five cycles after start.
    host_start = 1'b1;
    @(negedge clk);
    host_start = 1'b0;
    chk("start_core_rst_n", {31'b0, core_rst_n}, 1);
    chk("start_cycle_count", cycle_count, 0);
    core_drive(1'b1, 4'b0101, 32'h0000_0020, 32'hAABB_CCDD);
    @(negedge clk);
    core_drive(1'b1, 4'b0000, 32'h0000_0020, 32'h0);
    @(negedge clk);
    chk("lane_write_read", dmem_dout, 32'h00BB_00DD);
    core_drive(1'b1, 4'b0000, 32'h0000_2004, 32'h0);
    @(negedge clk);
    chk("core_read_count", dmem_dout, 2);
    core_drive(1'b1, 4'b0000, 32'h0000_2000, 32'h0);
    @(negedge clk);
    chk("core_read_status", dmem_dout, 0);
    core_drive(1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    core_drive(1'b1, 4'hF, 32'h0000_2000, 32'hDEAD_BEEF);
    @(negedge clk);
    core_drive(1'b0, 4'h0, 32'h0, 32'h0);
    chk("mbox_done", {31'b0, done}, 1);
    chk("mbox_timeout", {31'b0, timeout}, 0);
    chk("mbox_core_rst_n", {31'b0, core_rst_n}, 0);
    chk("mbox_cycle_count", cycle_count, 6);
    host_read_chk("mbox_host_status", 32'h0000_2000, 32'h1);
    host_read_chk("mbox_host_count", 32'h0000_2004, 32'h6);
    host_xfer(1'b1, 32'h0000_2004, 32'h1234_5678, rd, lat, aa);
    chk("mmio_ro_count", cycle_count, 6);

    // Timeout run with host request held pending throughout RUN.
    host_start = 1'b1;
    @(negedge clk);
    host_start = 1'b0;
    host_req  = 1'b1;
    host_we   = 1'b0;
    host_addr = 32'h0000_0020;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!host_ack && k < 40);
    rd = host_rdata;
    host_req = 1'b0;
    chk("pend_ack_cycle", k, 9);
    chk("pend_rdata", rd, 32'h00BB_00DD);
    chk("tmo_timeout", {31'b0, timeout}, 1);
    chk("tmo_done", {31'b0, done}, 0);
    chk("tmo_core_rst_n", {31'b0, core_rst_n}, 0);
    chk("tmo_cycle_count", cycle_count, 8);
    repeat (3) @(negedge clk);
    chk("tmo_count_frozen", cycle_count, 8);

    // Asynchronous reset mid-run; host_start during RUN must be ignored.
    host_start = 1'b1;
    @(negedge clk);
    host_start = 1'b0;
    core_drive(1'b1, 4'hF, 32'h0000_0030, 32'hCAFE_F00D);
    @(negedge clk);
    host_start = 1'b1;
    core_drive(1'b1, 4'h0, 32'h0000_0010, 32'h0);
    @(negedge clk);
    host_start = 1'b0;
    core_drive(1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    chk("run_start_ignored", cycle_count, 3);
    chk("run_dout_pre_rst", dmem_dout, 32'h1122_3344);
    #2 rst = 1'b1;
    #1;
    chk("arst_core_rst_n", {31'b0, core_rst_n}, 0);
    chk("arst_cycle_count", cycle_count, 0);
    chk("arst_done", {31'b0, done}, 0);
    chk("arst_timeout", {31'b0, timeout}, 0);
    chk("arst_dmem_dout", dmem_dout, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    host_read_chk("arst_mem_keep30", 32'h0000_0030, 32'hCAFE_F00D);
    host_read_chk("arst_mem_keep10", 32'h0000_0010, 32'h1122_3344);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
